simprisc_ctrl: RTL and testbench
================================

# simprisc_ctrl

Multi-cycle control sequencer for the simprisc RV32I arithmetic core. It fetches instructions over a request/grant instruction-memory port and decodes OP and OP-IMM instructions. It then drives the register file and ALU through decode, execute and writeback, and retires one instruction at a time. It sits between instruction memory and the existing register-file/ALU datapath, and is the block the arithmetic-instruction stimulus ultimately exercises.

## Interface
- XLEN, 32: datapath width.
- PC_RESET, 32'h0000_0000: PC value after reset.
- FETCH_TIMEOUT, 15: max cycles from grant to `imem_rvalid` before trapping.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; execute while high.
- halted  out  1  high in IDLE or TRAP.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (= PC).
- imem_gnt  in  1  request accepted.
- imem_rvalid  in  1  instruction data valid.
- imem_rdata  in  32  instruction word.
- rf_raddr1, rf_raddr2  out  5  source register addresses (rs1, rs2).
- rf_we  out  1  register write enable.
- rf_waddr  out  5  destination (rd).
- alu_op  out  4  `alu_op_e` operation select.
- alu_b_sel  out  1  0 = rs2 data, 1 = immediate.
- alu_imm  out  XLEN  sign-extended I-immediate.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  32  retired-instruction counter, wraps.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  0 none, 1 illegal, 2 fetch timeout.

## Operation
- Reset: PC=PC_RESET, state IDLE, instret=0, trap_cause=0. All other outputs are 0 and `halted` is 1.
- IDLE: when `run`=1, go to FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=PC, held stable until `imem_gnt`. On grant go to WAIT. `imem_rvalid` is ignored in FETCH.
- WAIT: the timeout counter counts from 0.
  - On `imem_rvalid`, latch IR and go to DECODE.
  - If the counter reaches FETCH_TIMEOUT with no rvalid, go to TRAP with cause 2.
- DECODE: drive rs1/rs2 onto `rf_raddr*` (held through EXEC) and run the decoder.
  - Illegal instruction: go to TRAP with cause 1.
  - Otherwise go to EXEC.
- EXEC: drive `alu_op`, `alu_b_sel` and `alu_imm` (held through WB). Register read data is valid in this state.
- WB:
  - `rf_we`=1 if rd≠0. `rf_waddr`=rd.
  - `retire` pulses, `instret`+1, PC+4 (wraps modulo 2^XLEN).
  - Next state is FETCH if `run`=1, else IDLE.
- Legal encodings:
  - opcode 0110011 with funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - opcode 0110011 with funct7 0100000: SUB, SRA.
  - opcode 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
  - SLLI/SRLI legal only with imm[11:5]=0000000. SRAI legal only with imm[11:5]=0100000.
  - Everything else is illegal.
- TRAP: `trap`=1 and `halted`=1; PC frozen at the faulting address. Leaves TRAP only on `rst`.
- `run` deasserted mid-instruction: the instruction completes through WB, then the block goes to IDLE.
- rd=x0 (e.g. NOP 0x00000013): retires with `rf_we`=0.

## Timing
- States: IDLE, FETCH, WAIT, DECODE, EXEC, WB, TRAP. All outputs are registered or decoded from the registered state.
- Minimum latency with grant in the first FETCH cycle and rvalid in the first WAIT cycle: 5 cycles per instruction, FETCH to WB inclusive. Back-to-back retire pulses are therefore 5 cycles apart.
- Memory handshake:
  - `imem_req` stays high until the cycle `imem_gnt` is sampled high.
  - At most one outstanding fetch.
  - `imem_rvalid` is expected no earlier than 1 cycle after grant.
- Timeout: trap is entered on the cycle after FETCH_TIMEOUT WAIT cycles without rvalid. An rvalid arriving in that same final cycle wins.
- Async `rst` mid-instruction: immediate return to reset values; any in-flight fetch is abandoned.

## Structure
- `simprisc_ctrl_pkg` holds:
  - `alu_op_e`: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - `ctrl_state_e`.
  - `trap_cause_e`.
  - OPCODE_OP and OPCODE_OP_IMM constants.
  - It is shared with the ALU and with the testbench predictor.
- One combinational sub-module, `simprisc_decoder`, maps IR to {alu_op, alu_b_sel, alu_imm, rs1, rs2, rd, illegal}. The FSM, PC, timeout and instret logic live in `simprisc_ctrl`.

## Test plan
- Reset then `run`=1, memory returns ADD x3,x1,x2 (0x002081B3):
  - required: `rf_raddr1`=1, `rf_raddr2`=2, `alu_op`=ADD, `alu_b_sel`=0;
  - `rf_we`=1 with `rf_waddr`=3 in WB;
  - `retire` on cycle 5, `instret`=1, next fetch address 0x4.
- ADDI x5,x0,-1 (0xFFF00293): `alu_b_sel`=1, `alu_imm`=0xFFFFFFFF, `rf_waddr`=5.
- SLLI with imm[11:5]=0000001 (0x02109093): TRAP, `trap_cause`=1, PC held at the faulting address. After `rst`, all outputs return to reset values.
- `imem_gnt` withheld 3 cycles, then no rvalid for 15 cycles: `imem_req` held for those 3 cycles; TRAP with `trap_cause`=2.
- `run` dropped during EXEC: the instruction retires, the block enters IDLE, no further `imem_req`.
- Stream of 4 NOPs (0x00000013): 4 retire pulses 5 cycles apart, `rf_we` never 1, `instret`=4, PC=0x10.

Source files
------------

// File: rtl/simprisc_ctrl_pkg.sv
// rtl/simprisc_ctrl_pkg.sv - shared types and constants for the simprisc control sequencer
//
// Holds the ALU operation encoding, the sequencer state encoding, trap causes
// and the two opcodes the core executes. The ALU and the testbench predictor
// import this package as well, so the encodings below are the shared contract.

package simprisc_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE          = 2'd0,
        CAUSE_ILLEGAL       = 2'd1,
        CAUSE_FETCH_TIMEOUT = 2'd2
    } trap_cause_e;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

endpackage

// File: rtl/simprisc_decoder.sv
// rtl/simprisc_decoder.sv - combinational OP / OP-IMM instruction decoder
//
// Ports:
//   ir        in   32    latched instruction word
//   alu_op    out  4     ALU operation select
//   alu_b_sel out  1     0 = rs2 data, 1 = immediate
//   alu_imm   out  XLEN  sign-extended I-immediate
//   rs1/rs2   out  5     source register fields
//   rd        out  5     destination register field
//   illegal   out  1     encoding outside the supported OP / OP-IMM subset

module simprisc_decoder
    import simprisc_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    output alu_op_e         alu_op,
    output logic            alu_b_sel,
    output logic [XLEN-1:0] alu_imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode  = ir[6:0];
    assign funct3  = ir[14:12];
    assign funct7  = ir[31:25];
    assign rd      = ir[11:7];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign alu_imm = {{(XLEN-12){ir[31]}}, ir[31:20]};

    always_comb begin
        alu_op    = ALU_ADD;
        alu_b_sel = 1'b0;
        illegal   = 1'b1;
        case (opcode)
            OPCODE_OP: begin
                if (funct7 == 7'b0000000) begin
                    illegal = 1'b0;
                    case (funct3)
                        3'd0:    alu_op = ALU_ADD;
                        3'd1:    alu_op = ALU_SLL;
                        3'd2:    alu_op = ALU_SLT;
                        3'd3:    alu_op = ALU_SLTU;
                        3'd4:    alu_op = ALU_XOR;
                        3'd5:    alu_op = ALU_SRL;
                        3'd6:    alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'd0) begin
                        alu_op  = ALU_SUB;
                        illegal = 1'b0;
                    end else if (funct3 == 3'd5) begin
                        alu_op  = ALU_SRA;
                        illegal = 1'b0;
                    end
                end
            end
            OPCODE_OP_IMM: begin
                alu_b_sel = 1'b1;
                case (funct3)
                    3'd0: begin alu_op = ALU_ADD;  illegal = 1'b0; end
                    3'd2: begin alu_op = ALU_SLT;  illegal = 1'b0; end
                    3'd3: begin alu_op = ALU_SLTU; illegal = 1'b0; end
                    3'd4: begin alu_op = ALU_XOR;  illegal = 1'b0; end
                    3'd6: begin alu_op = ALU_OR;   illegal = 1'b0; end
                    3'd7: begin alu_op = ALU_AND;  illegal = 1'b0; end
                    // Shift-immediates reuse imm[11:5] as a function field.
                    3'd1: begin
                        alu_op  = ALU_SLL;
                        illegal = (funct7 != 7'b0000000);
                    end
                    default: begin
                        if (funct7 == 7'b0000000) begin
                            alu_op  = ALU_SRL;
                            illegal = 1'b0;
                        end else if (funct7 == 7'b0100000) begin
                            alu_op  = ALU_SRA;
                            illegal = 1'b0;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/simprisc_ctrl.sv
// rtl/simprisc_ctrl.sv - multi-cycle fetch/decode/execute/writeback sequencer
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   run                 execute while high
//   halted, trap        status (IDLE or TRAP / TRAP only)
//   imem_req/addr       fetch request and address (= PC)
//   imem_gnt/rvalid     request accepted / instruction data valid
//   imem_rdata          instruction word
//   rf_raddr1/2         rs1/rs2, valid in DECODE and EXEC
//   rf_we/rf_waddr      register write in WB (suppressed for x0)
//   alu_op/b_sel/imm    ALU controls, valid in EXEC and WB
//   retire, instret     retire pulse in WB and wrapping retire counter
//   trap_cause          0 none, 1 illegal, 2 fetch timeout

module simprisc_ctrl
    import simprisc_ctrl_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] PC_RESET      = '0,
    parameter int              FETCH_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            halted,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output alu_op_e         alu_op,
    output logic            alu_b_sel,
    output logic [XLEN-1:0] alu_imm,
    output logic            retire,
    output logic [31:0]     instret,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    localparam int TCNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(FETCH_TIMEOUT - 1);

    ctrl_state_e     state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic [31:0]     instret_q;
    trap_cause_e     cause_q;

    alu_op_e         dec_alu_op;
    logic            dec_b_sel;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_illegal;

    simprisc_decoder #(.XLEN(XLEN)) u_decoder (
        .ir        (ir_q),
        .alu_op    (dec_alu_op),
        .alu_b_sel (dec_b_sel),
        .alu_imm   (dec_imm),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .rd        (dec_rd),
        .illegal   (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH:  if (imem_gnt) state_d = ST_WAIT;
            // rvalid is checked first so a response in the last allowed cycle wins.
            ST_WAIT: begin
                if (imem_rvalid)              state_d = ST_DECODE;
                else if (tcnt_q == TCNT_LAST) state_d = ST_TRAP;
            end
            ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = run ? ST_FETCH : ST_IDLE;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            tcnt_q    <= '0;
            instret_q <= '0;
            cause_q   <= CAUSE_NONE;
        end else begin
            case (state_q)
                ST_FETCH: tcnt_q <= '0;
                ST_WAIT: begin
                    if (imem_rvalid)              ir_q    <= imem_rdata;
                    else if (tcnt_q == TCNT_LAST) cause_q <= CAUSE_FETCH_TIMEOUT;
                    else                          tcnt_q  <= tcnt_q + 1'b1;
                end
                ST_DECODE: if (dec_illegal) cause_q <= CAUSE_ILLEGAL;
                ST_WB: begin
                    pc_q      <= pc_q + XLEN'(4);
                    instret_q <= instret_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    logic in_rd_phase, in_alu_phase, in_wb;

    assign in_rd_phase  = (state_q == ST_DECODE) || (state_q == ST_EXEC);
    assign in_alu_phase = (state_q == ST_EXEC)   || (state_q == ST_WB);
    assign in_wb        = (state_q == ST_WB);

    assign halted     = (state_q == ST_IDLE) || (state_q == ST_TRAP);
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign rf_raddr1  = in_rd_phase ? dec_rs1 : 5'd0;
    assign rf_raddr2  = in_rd_phase ? dec_rs2 : 5'd0;
    assign alu_op     = in_alu_phase ? dec_alu_op : ALU_ADD;
    assign alu_b_sel  = in_alu_phase && dec_b_sel;
    assign alu_imm    = in_alu_phase ? dec_imm : '0;
    assign rf_we      = in_wb && (dec_rd != 5'd0);
    assign rf_waddr   = in_wb ? dec_rd : 5'd0;
    assign retire     = in_wb;
    assign instret    = instret_q;

endmodule

// File: tb/tb_simprisc_ctrl.sv
// tb/tb_simprisc_ctrl.sv - directed self-checking bench for simprisc_ctrl

module tb_simprisc_ctrl;
    import simprisc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        halted;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        rf_we;
    alu_op_e     alu_op;
    logic        alu_b_sel;
    logic [31:0] alu_imm;
    logic        retire;
    logic [31:0] instret;
    logic        trap;
    logic [1:0]  trap_cause;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int retire_cyc[$];
    int we_cnt = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00293;
    localparam logic [31:0] I_SUB  = 32'h40208233;
    localparam logic [31:0] I_SLLI = 32'h02109093;
    localparam logic [31:0] I_NOP  = 32'h00000013;

    simprisc_ctrl #(
        .XLEN          (32),
        .PC_RESET      (32'h0000_0000),
        .FETCH_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .halted      (halted),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .alu_op      (alu_op),
        .alu_b_sel   (alu_b_sel),
        .alu_imm     (alu_imm),
        .retire      (retire),
        .instret     (instret),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (retire === 1'b1) retire_cyc.push_back(cyc);
        if (rf_we === 1'b1) we_cnt = we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From a sampled FETCH cycle: grant at once, rvalid in the first WAIT cycle.
    // Returns with the DUT in DECODE.
    task automatic fetch(input logic [31:0] word);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " halted"},     {31'd0, halted},     32'd1);
        check({tag, " imem_req"},   {31'd0, imem_req},   32'd0);
        check({tag, " imem_addr"},  imem_addr,           32'd0);
        check({tag, " instret"},    instret,             32'd0);
        check({tag, " trap"},       {31'd0, trap},       32'd0);
        check({tag, " trap_cause"}, {30'd0, trap_cause}, 32'd0);
        check({tag, " rf_we"},      {31'd0, rf_we},      32'd0);
        check({tag, " retire"},     {31'd0, retire},     32'd0);
        check({tag, " rf_raddr1"},  {27'd0, rf_raddr1},  32'd0);
        check({tag, " alu_imm"},    alu_imm,             32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int qb, wb, reqs;

        // Reset state
        tick();
        tick();
        check_reset_values("rst");
        rst = 1'b0;

        // ADD x3,x1,x2
        run = 1'b1;
        tick();
        check("add fetch req",  {31'd0, imem_req}, 32'd1);
        check("add fetch addr", imem_addr,         32'h0);
        check("add fetch halted", {31'd0, halted}, 32'd0);
        fetch(I_ADD);
        check("add dec raddr1", {27'd0, rf_raddr1}, 32'd1);
        check("add dec raddr2", {27'd0, rf_raddr2}, 32'd2);
        tick();
        check("add exec alu_op", {28'd0, alu_op},    {28'd0, ALU_ADD});
        check("add exec b_sel",  {31'd0, alu_b_sel}, 32'd0);
        check("add exec raddr1", {27'd0, rf_raddr1}, 32'd1);
        tick();
        check("add wb rf_we",  {31'd0, rf_we},     32'd1);
        check("add wb waddr",  {27'd0, rf_waddr},  32'd3);
        check("add wb retire", {31'd0, retire},    32'd1);
        tick();
        check("add instret",   instret,            32'd1);
        check("add next addr", imem_addr,          32'h4);
        check("add next req",  {31'd0, imem_req},  32'd1);
        check("add retire low", {31'd0, retire},   32'd0);

        // ADDI x5,x0,-1
        fetch(I_ADDI);
        tick();
        check("addi b_sel",  {31'd0, alu_b_sel}, 32'd1);
        check("addi imm",    alu_imm,            32'hFFFF_FFFF);
        check("addi alu_op", {28'd0, alu_op},    {28'd0, ALU_ADD});
        tick();
        check("addi waddr",  {27'd0, rf_waddr},  32'd5);
        check("addi rf_we",  {31'd0, rf_we},     32'd1);
        tick();
        check("addi instret", instret,           32'd2);
        check("addi addr",    imem_addr,         32'h8);

        // SUB x4,x1,x2 with run dropped during EXEC
        fetch(I_SUB);
        tick();
        run = 1'b0;
        check("sub alu_op", {28'd0, alu_op}, {28'd0, ALU_SUB});
        tick();
        check("stop retire", {31'd0, retire}, 32'd1);
        tick();
        check("stop halted",  {31'd0, halted}, 32'd1);
        check("stop instret", instret,         32'd3);
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req === 1'b1) reqs++;
            tick();
        end
        check("stop no req", reqs,      32'd0);
        check("stop addr",   imem_addr, 32'hC);

        // Async reset, then a stream of 4 NOPs
        #2 rst = 1'b1;
        #1;
        check("async rst instret", instret,          32'd0);
        check("async rst halted",  {31'd0, halted},  32'd1);
        tick();
        rst = 1'b0;
        run = 1'b1;
        qb = retire_cyc.size();
        wb = we_cnt;
        tick();
        for (int i = 0; i < 4; i++) begin
            fetch(I_NOP);
            tick();
            tick();
            tick();
        end
        check("nop retire count", retire_cyc.size() - qb, 32'd4);
        if (retire_cyc.size() - qb == 4) begin
            for (int i = 1; i < 4; i++)
                check("nop retire spacing", retire_cyc[qb+i] - retire_cyc[qb+i-1], 32'd5);
        end
        check("nop rf_we never", we_cnt - wb, 32'd0);
        check("nop instret",     instret,     32'd4);
        check("nop pc",          imem_addr,   32'h10);

        // Illegal SLLI (imm[11:5]=0000001) at PC 0x10
        fetch(I_SLLI);
        tick();
        check("ill trap",   {31'd0, trap},       32'd1);
        check("ill cause",  {30'd0, trap_cause}, 32'd1);
        check("ill halted", {31'd0, halted},     32'd1);
        check("ill pc",     imem_addr,           32'h10);
        tick();
        tick();
        tick();
        check("ill trap held", {31'd0, trap},     32'd1);
        check("ill pc held",   imem_addr,         32'h10);
        check("ill no req",    {31'd0, imem_req}, 32'd0);
        check("ill instret",   instret,           32'd4);
        check("ill no retire", {31'd0, retire},   32'd0);

        rst = 1'b1;
        #2;
        check_reset_values("post-trap rst");
        tick();
        rst = 1'b0;

        // rvalid in the 15th WAIT cycle wins over the timeout
        tick();
        check("late fetch req", {31'd0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("late still waiting", {31'd0, trap}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = I_NOP;
        tick();
        imem_rvalid = 1'b0;
        check("late no trap", {31'd0, trap}, 32'd0);
        tick();
        tick();
        check("late retire", {31'd0, retire}, 32'd1);
        tick();
        check("late instret", instret, 32'd1);

        // Grant withheld 3 cycles, then no rvalid: fetch timeout
        for (int i = 0; i < 3; i++) begin
            check("gnt wait req",  {31'd0, imem_req}, 32'd1);
            check("gnt wait addr", imem_addr,         32'h4);
            tick();
        end
        check("gnt final req", {31'd0, imem_req}, 32'd1);
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = I_ADD;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        check("to req dropped", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 14; i++) tick();
        check("to before limit", {31'd0, trap}, 32'd0);
        tick();
        check("to trap",   {31'd0, trap},       32'd1);
        check("to cause",  {30'd0, trap_cause}, 32'd2);
        check("to pc",     imem_addr,           32'h4);
        check("to halted", {31'd0, halted},     32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
